// File: rtl/tawas_thread_sched.sv
// Round-robin hardware-thread issue scheduler for the Tawas barrel core.
// Tracks each issued thread through load, decode and store stages.
module tawas_thread_sched #(
    parameter int THREADS = 32,
    parameter int TW      = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [THREADS-1:0] thread_mask,
    input  logic [THREADS-1:0] rcn_stall,
    input  logic               halt,
    output logic               thread_load_en,
    output logic [TW-1:0]      thread_load,
    output logic               thread_decode_en,
    output logic [TW-1:0]      thread_decode,
    output logic               thread_store_en,
    output logic [TW-1:0]      thread_store,
    output logic               idle,
    output logic [31:0]        issue_count
);

    localparam logic [TW-1:0] LAST_ID = TW'(THREADS - 1);

    logic [THREADS-1:0] inflight;
    logic [THREADS-1:0] eligible;
    logic [TW-1:0]      ptr;
    logic [TW-1:0]      sel;
    logic               sel_valid;
    logic               issue;

    // A thread still in load or decode may not reissue; store does not block.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < THREADS; i++) begin
            inflight[i] = (thread_load_en && thread_load == TW'(i)) ||
                          (thread_decode_en && thread_decode == TW'(i));
        end
    end

    assign eligible = thread_mask & ~rcn_stall & ~inflight;

    // First eligible thread after the last one issued, wrapping at THREADS.
    always_comb begin
        sel_valid = 1'b0;
        sel       = '0;
        for (int k = 1; k <= THREADS; k++) begin
            if (!sel_valid && eligible[(int'(ptr) + k) % THREADS]) begin
                sel_valid = 1'b1;
                sel       = TW'((int'(ptr) + k) % THREADS);
            end
        end
    end

    assign issue = sel_valid && !halt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            thread_load_en   <= 1'b0;
            thread_load      <= '0;
            thread_decode_en <= 1'b0;
            thread_decode    <= '0;
            thread_store_en  <= 1'b0;
            thread_store     <= '0;
            issue_count      <= '0;
            ptr              <= LAST_ID;
        end else begin
            thread_decode_en <= thread_load_en;
            thread_decode    <= thread_load;
            thread_store_en  <= thread_decode_en;
            thread_store     <= thread_decode;
            thread_load_en   <= issue;
            if (issue) begin
                thread_load <= sel;
                ptr         <= sel;
                issue_count <= issue_count + 32'd1;
            end
        end
    end

    assign idle = !thread_load_en && !thread_decode_en &&
                  !thread_store_en && !(|eligible);

endmodule

// File: tb/tb_tawas_thread_sched.sv
// Bench for tawas_thread_sched: issue-history reference model plus
// directed sequences and randomized mask/stall/halt/reset traffic.
module tb_tawas_thread_sched;

    localparam int N = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [N-1:0]  mask = '0;
    logic [N-1:0]  stall = '0;
    logic          halt = 1'b0;

    logic          ld_en, dec_en, st_en, idle;
    logic [4:0]    ld, dec, st;
    logic [31:0]   cnt;

    logic          l1_en, d1_en, s1_en, idle1;
    logic [0:0]    l1, d1, s1;
    logic [31:0]   cnt1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tawas_thread_sched #(.THREADS(N), .TW(5)) dut (
        .clk(clk), .rst(rst),
        .thread_mask(mask), .rcn_stall(stall), .halt(halt),
        .thread_load_en(ld_en), .thread_load(ld),
        .thread_decode_en(dec_en), .thread_decode(dec),
        .thread_store_en(st_en), .thread_store(st),
        .idle(idle), .issue_count(cnt)
    );

    tawas_thread_sched #(.THREADS(1), .TW(1)) dut1 (
        .clk(clk), .rst(rst),
        .thread_mask(1'b1), .rcn_stall(1'b0), .halt(1'b0),
        .thread_load_en(l1_en), .thread_load(l1),
        .thread_decode_en(d1_en), .thread_decode(d1),
        .thread_store_en(s1_en), .thread_store(s1),
        .idle(idle1), .issue_count(cnt1)
    );

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a thread may issue again once 3 edges have passed
    // since its last issue; outputs are the last three issue slots.
    longint      cyc;
    longint      last_issue [N];
    bit          m_ld_en, m_dec_en, m_st_en;
    int          m_ld, m_dec, m_st, m_ptr;
    int unsigned m_cnt;

    function automatic bit m_elig(int i);
        return mask[i] && !stall[i] && (cyc + 1 - last_issue[i] > 2);
    endfunction

    task automatic m_reset();
        for (int i = 0; i < N; i++) last_issue[i] = -100;
        m_ld_en = 0; m_dec_en = 0; m_st_en = 0;
        m_ld = 0; m_dec = 0; m_st = 0;
        m_ptr = N - 1;
        m_cnt = 0;
    endtask

    task automatic m_step();
        int pick;
        pick = -1;
        if (!halt) begin
            for (int k = 1; k <= N; k++) begin
                if (pick < 0 && m_elig((m_ptr + k) % N)) pick = (m_ptr + k) % N;
            end
        end
        m_st_en = m_dec_en; m_st = m_dec;
        m_dec_en = m_ld_en; m_dec = m_ld;
        m_ld_en = (pick >= 0);
        if (pick >= 0) begin
            m_ld = pick;
            m_ptr = pick;
            last_issue[pick] = cyc + 1;
            m_cnt = m_cnt + 1;
        end
        cyc++;
    endtask

    initial begin
        cyc = 0;
        m_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) m_reset();
            else m_step();
        end
    end

    initial begin
        bit any;
        forever begin
            @(negedge clk);
            any = 0;
            for (int i = 0; i < N; i++) if (m_elig(i)) any = 1;
            chk("load_en", ld_en, m_ld_en);
            chk("load", ld, m_ld);
            chk("decode_en", dec_en, m_dec_en);
            chk("decode", dec, m_dec);
            chk("store_en", st_en, m_st_en);
            chk("store", st, m_st);
            chk("issue_count", cnt, m_cnt);
            chk("idle", idle, !m_ld_en && !m_dec_en && !m_st_en && !any);
        end
    end

    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [N-1:0] mk, input logic [N-1:0] sk);
        @(negedge clk);
        #2 rst = 1'b1;
        mask = mk;
        stall = sk;
        halt = 1'b0;
        @(negedge clk);
        #2 rst = 1'b0;
    endtask

    initial begin
        int eb[6];
        int el[6];
        int ec[10];

        #1 rst = 1'b1;
        #1;
        chk("rst_load_en", ld_en, 0);
        chk("rst_decode_en", dec_en, 0);
        chk("rst_store_en", st_en, 0);
        chk("rst_load", ld, 0);
        chk("rst_count", cnt, 0);
        chk("rst_idle", idle, 1);

        // Full mask: 0..31,0 back to back, decode/store lag.
        mask = '1;
        @(negedge clk);
        #2 rst = 1'b0;
        for (int i = 0; i < 33; i++) begin
            edge1();
            chk("rr_load_en", ld_en, 1);
            chk("rr_load", ld, i % 32);
            if (i >= 1) chk("rr_decode", dec, (i - 1) % 32);
            if (i >= 2) chk("rr_store", st, (i - 2) % 32);
            if (i < 6) begin
                chk("t1_load_en", l1_en, (i % 3 == 0) ? 1 : 0);
                chk("t1_load", l1, 0);
            end
        end
        chk("rr_count33", cnt, 33);

        // Sparse mask 0x5: 0,2,bubble repeating.
        eb = '{1, 1, 0, 1, 1, 0};
        el = '{0, 2, 2, 0, 2, 2};
        do_reset(32'h5, 32'h0);
        for (int i = 0; i < 6; i++) begin
            edge1();
            chk("m5_load_en", ld_en, eb[i]);
            chk("m5_load", ld, el[i]);
            chk("m5_idle", idle, 0);
        end

        // Thread 1 stalled, then released.
        ec = '{0, 2, 3, 0, 2, 3, 0, 1, 2, 3};
        do_reset(32'hF, 32'h2);
        for (int i = 0; i < 10; i++) begin
            edge1();
            if (i == 5) stall = '0;
            chk("stall_load_en", ld_en, 1);
            chk("stall_load", ld, ec[i]);
        end

        // Halt after thread 4 issues, drain, resume at 5.
        do_reset('1, '0);
        for (int i = 0; i < 5; i++) edge1();
        chk("h_load4", ld, 4);
        halt = 1'b1;
        edge1();
        chk("h_load_en0", ld_en, 0);
        chk("h_load_hold", ld, 4);
        chk("h_dec_en1", dec_en, 1);
        chk("h_st_en1", st_en, 1);
        edge1();
        chk("h_dec_en0", dec_en, 0);
        chk("h_st_en1b", st_en, 1);
        edge1();
        chk("h_st_en0", st_en, 0);
        chk("h_idle_masked_on", idle, 0);
        mask = '0;
        #1 chk("h_idle_mask0", idle, 1);
        mask = '1;
        halt = 1'b0;
        edge1();
        chk("h_resume5", ld, 5);
        chk("h_count6", cnt, 6);

        // Asynchronous reset with all stages valid.
        edge1();
        edge1();
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("ar_load_en", ld_en, 0);
        chk("ar_dec_en", dec_en, 0);
        chk("ar_st_en", st_en, 0);
        chk("ar_count", cnt, 0);
        #1 rst = 1'b0;
        edge1();
        chk("ar_first_load", ld, 0);
        chk("ar_first_en", ld_en, 1);
        chk("ar_count1", cnt, 1);

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            edge1();
            if ($urandom_range(0, 7) == 0) begin
                case ($urandom_range(0, 3))
                    0: mask = '1;
                    1: mask = $urandom;
                    2: mask = (32'h1 << $urandom_range(0, 31)) |
                              (32'h1 << $urandom_range(0, 31));
                    default: mask = $urandom & $urandom;
                endcase
            end
            stall = ($urandom_range(0, 3) == 0) ? '0 : ($urandom & $urandom & $urandom);
            halt = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 199) == 0) begin
                rst = 1'b1;
                #2 rst = 1'b0;
            end
        end

        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tawas_thread_sched.md
TAWAS_THREAD_SCHED -- requirements
Module: tawas_thread_sched

Interface
REQ-001 SHALL provide parameter THREADS, default 32, number of hardware threads (legal 1..32).
REQ-002 SHALL provide parameter TW, default 5, thread ID width; SHALL satisfy 2^TW >= THREADS.
REQ-003 SHALL provide port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL provide port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL provide port thread_mask  input  THREADS  1 = thread enabled.
REQ-006 SHALL provide port rcn_stall  input  THREADS  1 = thread blocked on bus load.
REQ-007 SHALL provide port halt  input  1  1 = no new issue; pipeline drains.
REQ-008 SHALL provide port thread_load_en  output  1  load stage valid.
REQ-009 SHALL provide port thread_load  output  TW  load stage thread ID.
REQ-010 SHALL provide port thread_decode_en  output  1  decode stage valid.
REQ-011 SHALL provide port thread_decode  output  TW  decode stage thread ID.
REQ-012 SHALL provide port thread_store_en  output  1  store stage valid.
REQ-013 SHALL provide port thread_store  output  TW  store stage thread ID.
REQ-014 SHALL provide port idle  output  1  pipeline empty and no eligible thread.
REQ-015 SHALL provide port issue_count  output  32  total threads issued.

Function
REQ-016 SHALL register all outputs except idle, which is combinational from registered state and inputs.
REQ-017 SHALL compute eligible[i] = thread_mask[i] & ~rcn_stall[i] & ~inflight[i], inflight[i] = (load_en & load==i) | (decode_en & decode==i); store stage does not block reissue.
REQ-018 SHALL select, each cycle, the first eligible thread searching from (ptr+1) mod THREADS upward, wrapping THREADS-1 -> 0.
REQ-019 SHALL, when a thread is selected and halt=0, set thread_load_en=1 and thread_load=selected on the next edge, and set ptr=selected.
REQ-020 SHALL, when no thread is eligible or halt=1, set thread_load_en=0, hold thread_load at its prior value, and hold ptr.
REQ-021 SHALL advance every edge: decode <= load, store <= decode, including enables; no stalling of advanced stages.
REQ-022 SHALL bound per-thread issue rate to once per 3 cycles; THREADS=1 issues every 3rd cycle.
REQ-023 SHALL let instructions already issued complete when their mask bit clears or their stall bit sets mid-flight.
REQ-024 SHALL increment issue_count by 1 on each edge that sets thread_load_en=1; wraps 0xFFFFFFFF -> 0.
REQ-025 SHALL drive idle=1 iff load_en, decode_en, store_en all 0 and no thread eligible.
REQ-026 SHALL ignore mask/stall bits above THREADS-1 (none exist; IDs >= THREADS never issued).

Reset
REQ-027 SHALL, on rst high, immediately clear thread_load_en, thread_decode_en, thread_store_en, issue_count to 0 and IDs to 0, independent of clk.
REQ-028 SHALL reset ptr to THREADS-1 so first issue after reset is lowest eligible ID >= 0.
REQ-029 SHALL, on reset mid-operation, discard all in-flight stages; first post-reset issue occurs on the first edge after rst deasserts.

Verification
REQ-030 SHALL cover: THREADS=32, mask=0xFFFFFFFF, stall=0 -> thread_load 0,1,...,31,0 every cycle; decode/store lag 1/2 cycles; issue_count=33 after 33 issues.
REQ-031 SHALL cover: mask=0x00000005 -> load sequence 0,2,bubble,0,2,bubble; idle stays 0.
REQ-032 SHALL cover: THREADS=1, mask=0x1 -> load_en pattern 1,0,0,1,0,0; thread_load=0.
REQ-033 SHALL cover: mask=0xF, rcn_stall=0x2 -> sequence 0,2,3,0,2,3; clear stall -> 1 issued at its turn.
REQ-034 SHALL cover: halt=1 after thread 4 issued -> load_en 0 next edge, decode_en/store_en drain over 2 edges, idle=1 only if mask=0; halt=0 -> resume at 5.
REQ-035 SHALL cover: rst asserted between edges with all stages valid -> all enables 0 before next edge; after release, first load=0, issue_count=1.
